// File: rtl/multi_phase_clock_gen_pkg.sv
// Shared types and helpers for the multi-phase clock generator.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        CH_RUN  = 2'd0,
        CH_PEND = 2'd1,
        CH_HOLD = 2'd2
    } ch_state_e;

    // Width of a phase field for a given divide ratio (at least one bit).
    function automatic int unsigned phase_width(input int unsigned div);
        return (div > 2) ? $clog2(div) : 32'd1;
    endfunction

    function automatic int unsigned mod_inc(input int unsigned v, input int unsigned m);
        return (v + 32'd1 >= m) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/multi_phase_clock_gen_phase_channel.sv
// One output channel: local counter, phase-change FSM and registered clock.
module phase_channel
    import clk_gen_pkg::*;
#(
    parameter int unsigned DIV  = 4,
    parameter int unsigned HIGH = DIV / 2,
    parameter int unsigned PW   = phase_width(DIV)
) (
    input  logic          clk160,
    input  logic          rst_n,
    input  logic [PW-1:0] g_next,
    input  logic [PW-1:0] phase_sel,
    input  logic          phase_load,
    output logic          busy,
    output logic          load_err,
    output logic          clk_out,
    output logic [PW-1:0] phase_cur
);
    localparam logic [PW-1:0] LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] HIGH_W = PW'(HIGH);
    localparam logic [PW:0]   DIV_W  = (PW + 1)'(DIV);

    ch_state_e     state, state_nxt;
    logic [PW-1:0] lcnt, lcnt_nxt;
    logic [PW-1:0] phase_new, phase_new_nxt, phase_cur_nxt;
    logic          err_nxt;
    logic          realign;

    assign realign = (g_next == phase_new);

    always_comb begin
        state_nxt     = state;
        lcnt_nxt      = lcnt;
        phase_new_nxt = phase_new;
        phase_cur_nxt = phase_cur;
        err_nxt       = 1'b0;
        case (state)
            CH_RUN: begin
                lcnt_nxt = PW'(mod_inc(32'(lcnt), DIV));
                if (phase_load) begin
                    if ({1'b0, phase_sel} < DIV_W) begin
                        phase_new_nxt = phase_sel;
                        state_nxt     = CH_PEND;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            CH_PEND: begin
                // The change is only applied at a period boundary; otherwise park at LAST.
                if (lcnt == LAST) begin
                    if (realign) begin
                        lcnt_nxt      = '0;
                        phase_cur_nxt = phase_new;
                        state_nxt     = CH_RUN;
                    end else begin
                        state_nxt = CH_HOLD;
                    end
                end else begin
                    lcnt_nxt = PW'(mod_inc(32'(lcnt), DIV));
                end
            end
            CH_HOLD: begin
                if (realign) begin
                    lcnt_nxt      = '0;
                    phase_cur_nxt = phase_new;
                    state_nxt     = CH_RUN;
                end
            end
            default: state_nxt = CH_RUN;
        endcase
    end

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CH_RUN;
            lcnt      <= LAST;
            phase_new <= '0;
            phase_cur <= '0;
            busy      <= 1'b0;
            load_err  <= 1'b0;
            clk_out   <= 1'b0;
        end else begin
            state     <= state_nxt;
            lcnt      <= lcnt_nxt;
            phase_new <= phase_new_nxt;
            phase_cur <= phase_cur_nxt;
            busy      <= (state_nxt != CH_RUN);
            load_err  <= err_nxt;
            clk_out   <= (lcnt_nxt < HIGH_W);
        end
    end

endmodule

// File: rtl/multi_phase_clock_gen.sv
// Multi-channel divided clock generator with glitch-free run-time phase changes.
module multi_phase_clock_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned DIV  = 4,
    parameter int unsigned HIGH = DIV / 2,
    parameter int unsigned NCH  = 4,
    parameter int unsigned PW   = phase_width(DIV)
) (
    input  logic              clk160,
    input  logic              rst_n,
    input  logic [NCH*PW-1:0] phase_sel,
    input  logic [NCH-1:0]    phase_load,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    load_err,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH*PW-1:0] phase_cur,
    output logic              frame_sync
);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] g, g_next;

    assign g_next = PW'(mod_inc(32'(g), DIV));

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            g          <= LAST;
            frame_sync <= 1'b0;
        end else begin
            g          <= g_next;
            frame_sync <= (g_next == '0);
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        phase_channel #(
            .DIV  (DIV),
            .HIGH (HIGH),
            .PW   (PW)
        ) u_ch (
            .clk160     (clk160),
            .rst_n      (rst_n),
            .g_next     (g_next),
            .phase_sel  (phase_sel[c*PW +: PW]),
            .phase_load (phase_load[c]),
            .busy       (busy[c]),
            .load_err   (load_err[c]),
            .clk_out    (clk_out[c]),
            .phase_cur  (phase_cur[c*PW +: PW])
        );
    end

endmodule

// File: tb/tb_multi_phase_clock_gen.sv
// Randomised bench for multi_phase_clock_gen against a period-timing reference model.
module tb_multi_phase_clock_gen;
    localparam int unsigned HIGH = 2;

    logic       clk160 = 1'b0;
    logic       rst_n  = 1'b1;

    logic [3:0] sel4  = '0;
    logic [1:0] ld4   = '0;
    logic [1:0] busy4, err4, clk4;
    logic [3:0] cur4;
    logic       fs4;

    logic [5:0] sel5  = '0;
    logic [1:0] ld5   = '0;
    logic [1:0] busy5, err5, clk5;
    logic [5:0] cur5;
    logic       fs5;

    always #5 clk160 = ~clk160;

    multi_phase_clock_gen #(.DIV(4), .HIGH(HIGH), .NCH(2)) u_dut4 (
        .clk160     (clk160),
        .rst_n      (rst_n),
        .phase_sel  (sel4),
        .phase_load (ld4),
        .busy       (busy4),
        .load_err   (err4),
        .clk_out    (clk4),
        .phase_cur  (cur4),
        .frame_sync (fs4)
    );

    multi_phase_clock_gen #(.DIV(5), .HIGH(HIGH), .NCH(2)) u_dut5 (
        .clk160     (clk160),
        .rst_n      (rst_n),
        .phase_sel  (sel5),
        .phase_load (ld5),
        .busy       (busy5),
        .load_err   (err5),
        .clk_out    (clk5),
        .phase_cur  (cur5),
        .frame_sync (fs5)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model: n is the edge index since reset release; a pending change applies at
    // time m_t, and the output is forced low from the old period end e_t until m_t.
    int n;
    int ph   [2][2];
    int pnew [2][2];
    int e_t  [2][2];
    int m_t  [2][2];
    bit pend [2][2];
    bit perr [2][2];

    function automatic int div_of(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic int pmod(input int a, input int m);
        return ((a % m) + m) % m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s (n=%0d): got %0d expected %0d", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = -1;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                ph[d][c] = 0; pnew[d][c] = 0; e_t[d][c] = 0; m_t[d][c] = 0;
                pend[d][c] = 1'b0; perr[d][c] = 1'b0;
            end
    endtask

    task automatic model_edge();
        int div, s;
        bit ld, was_busy;
        n++;
        for (int d = 0; d < 2; d++) begin
            div = div_of(d);
            for (int c = 0; c < 2; c++) begin
                ld = (d == 0) ? ld4[c] : ld5[c];
                s  = (d == 0) ? int'(sel4[c*2 +: 2]) : int'(sel5[c*3 +: 3]);
                was_busy = pend[d][c];
                perr[d][c] = 1'b0;
                if (pend[d][c] && n == m_t[d][c]) begin
                    ph[d][c]   = pnew[d][c];
                    pend[d][c] = 1'b0;
                end
                if (ld && !was_busy) begin
                    if (s >= div) begin
                        perr[d][c] = 1'b1;
                    end else begin
                        pnew[d][c] = s;
                        pend[d][c] = 1'b1;
                        e_t[d][c]  = n + 1 + pmod(ph[d][c] - (n + 1), div);
                        m_t[d][c]  = e_t[d][c] + pmod(s - ph[d][c], div);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        int div;
        logic exp_clk;
        for (int d = 0; d < 2; d++) begin
            div = div_of(d);
            check(d == 0 ? "fs4" : "fs5", d == 0 ? fs4 : fs5,
                  (n >= 0) && (n % div == 0));
            for (int c = 0; c < 2; c++) begin
                if (n < 0)
                    exp_clk = 1'b0;
                else if (pend[d][c] && n >= e_t[d][c])
                    exp_clk = 1'b0;
                else
                    exp_clk = (pmod(n - ph[d][c], div) < HIGH);
                check($sformatf("clk_out d%0d c%0d", div, c),
                      d == 0 ? clk4[c] : clk5[c], exp_clk);
                check($sformatf("busy d%0d c%0d", div, c),
                      d == 0 ? busy4[c] : busy5[c], pend[d][c]);
                check($sformatf("load_err d%0d c%0d", div, c),
                      d == 0 ? err4[c] : err5[c], perr[d][c]);
                check($sformatf("phase_cur d%0d c%0d", div, c),
                      d == 0 ? 32'(cur4[c*2 +: 2]) : 32'(cur5[c*3 +: 3]), ph[d][c]);
            end
        end
    endtask

    // Drive inputs away from the edge, advance one clock, then compare.
    task automatic tick(input logic [1:0] l4, input logic [3:0] s4,
                        input logic [1:0] l5, input logic [5:0] s5);
        ld4 = l4; sel4 = s4; ld5 = l5; sel5 = s5;
        @(posedge clk160);
        if (rst_n) model_edge();
        #1 check_all();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick('0, '0, '0, '0);
    endtask

    initial begin
        bit reached;
        model_reset();
        #1 rst_n = 1'b0;
        idle(2);

        // Release: both DUTs run phase 0.
        rst_n = 1'b1;
        idle(12);

        // DIV=4 ch1 -> phase 2.
        tick(2'b10, {2'd2, 2'd0}, '0, '0);
        idle(12);

        // DIV=5 ch0 invalid phase 7.
        tick('0, '0, 2'b01, {3'd0, 3'd7});
        idle(6);

        // DIV=4 ch0: phase 1 then phase 3 while busy.
        tick(2'b01, {2'd0, 2'd1}, '0, '0);
        tick(2'b01, {2'd0, 2'd3}, '0, '0);
        idle(10);

        // DIV=5 ch1 reload of its current phase 0.
        tick('0, '0, 2'b10, {3'd0, 3'd0});
        idle(8);

        // DIV=4 ch1: large stretch, then reset while held low.
        tick(2'b10, {2'(ph[0][1] + 3), 2'd0}, '0, '0);
        reached = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pend[0][1] && n >= e_t[0][1]) begin
                reached = 1'b1;
                break;
            end
            idle(1);
        end
        check("hold_reached", reached, 1'b1);
        #3 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        idle(2);
        rst_n = 1'b1;
        idle(12);

        // Random loads on both DUTs, including out-of-range phases on DIV=5.
        for (int i = 0; i < 400; i++) begin
            tick({$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0}, 4'($urandom),
                 {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0}, 6'($urandom));
            if ($urandom_range(0, 99) == 0) begin
                #3 rst_n = 1'b0;
                #1 model_reset();
                check_all();
                idle(1);
                rst_n = 1'b1;
            end
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_phase_clock_gen.md
# multi_phase_clock_gen

Parametrised successor to the single-channel 160 MHz phase picker. Derives NCH divided clocks from `clk160`, each with an independently selectable start phase, a programmable divide ratio and a programmable high time. Each channel accepts phase changes at run time through a per-channel load/busy handshake. Changes are glitch-free: the low time is only ever stretched, never shortened, and no runt pulse is produced. The block sits in the on-chip clocking area and feeds emulated front-end clock domains.

## Interface

Parameters:
- `DIV`, default 4: divide ratio, ≥2 (4 gives 40 MHz from `clk160`).
- `HIGH`, default DIV/2: high cycles per period, 1..DIV-1.
- `NCH`, default 4: number of output channels, ≥1.
- `PW`, default $clog2(DIV): phase field width (derived, not overridden).

Ports:
- `clk160`, in, 1: the only clock.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `phase_sel`, in, NCH*PW: requested phase; slice c belongs to channel c.
- `phase_load`, in, NCH: per-channel load strobe, sampled on the rising edge.
- `busy`, out, NCH: a phase change is pending on channel c.
- `load_err`, out, NCH: one-cycle pulse when a load is rejected.
- `clk_out`, out, NCH: divided clocks (registered).
- `phase_cur`, out, NCH*PW: phase currently in effect per channel.
- `frame_sync`, out, 1: one-cycle pulse when the global counter is 0.

## Operation

- Global counter `g` runs 0..DIV-1 and wraps; it has its own wrap logic, so non-power-of-2 DIV is legal.
- Per-channel local counter `lcnt`, 0..DIV-1.
  - Steady-state invariant: `lcnt == (g - phase_cur) mod DIV`.
  - `clk_out[c] == (lcnt < HIGH)`.
- Channel states:
  - RUN: `lcnt` increments and wraps.
  - PEND: same counting as RUN; a new phase is held in `phase_new`.
  - HOLD: `lcnt` frozen at DIV-1, `clk_out` held 0.
- Load acceptance:
  - Accepted when `phase_load[c]`=1, `busy[c]`=0 and the slice is < DIV.
  - Capture `phase_new`, go to PEND, set `busy`.
- Load rejection:
  - Slice ≥ DIV: reject, pulse `load_err`, state unchanged.
  - `phase_load` while `busy`=1: ignored silently, no `load_err`.
- Realign condition: state is PEND with `lcnt`==DIV-1, or state is HOLD; and `(g+1) mod DIV == phase_new`.
  - On that edge: `lcnt`←0, `clk_out`←1, `phase_cur`←`phase_new`, state RUN, `busy`←0.
- PEND with `lcnt`==DIV-1 and realign condition false → HOLD.
- Extra low time on a change = (new − old) mod DIV cycles.
  - Reloading the current phase adds zero stretch; `busy` clears at the next period start.
- Channels are fully independent. Loads on several channels in the same cycle are all handled.

## Timing

- All outputs come from registers; there is no combinational input→output path.
- Reset values:
  - `g`=DIV-1; every `lcnt`=DIV-1; `phase_cur`=0.
  - `clk_out`=0, `busy`=0, `load_err`=0, `frame_sync`=0.
  - State RUN.
- First rising edge after `rst_n` deasserts:
  - `g`=0, `frame_sync`=1.
  - Every `clk_out`=1 (all channels start on phase 0).
- Accepted load at edge k:
  - `busy`=1 after edge k.
  - `busy` falls on the same edge as the first `clk_out` rise at the new phase.
- Worst-case `busy` duration: 2·DIV−1 cycles.
- `load_err` is high for exactly the cycle after the rejecting edge.
- Load accepted on the same edge where the channel would already wrap (`lcnt`=DIV-1 in RUN): the period completes, the channel enters PEND, and the realign is evaluated at the next `lcnt`=DIV-1. Changes are never applied mid-period.
- `rst_n` asserted mid-operation: all state returns to reset values immediately and the pending change is discarded.
- The high phase is always exactly HIGH cycles. Low is DIV−HIGH cycles, plus the stretch on a change.

## Structure

- Package `clk_gen_pkg` holds:
  - the channel state enum (RUN/PEND/HOLD);
  - the `phase_t` width helper, derived from DIV;
  - a modular-increment function shared by the global and local counters.
- Top level holds the global counter and `frame_sync`.
- Sub-module `phase_channel` (one instance per channel) holds `lcnt`, the FSM, `phase_cur`/`phase_new`, `busy`, `load_err` and `clk_out`. It receives `g_next` from the top.

## Test plan

1. Reset release, DIV=4, HIGH=2, NCH=2 → both `clk_out` show 1,1,0,0 repeating from the first edge; `frame_sync` on cycles 0, 4, 8.
2. Load phase 2 on ch1 at a steady state → ch1 low stretched to 4 cycles, then 1100 lagging ch0 by 2; `busy` high until that rise; `phase_cur[1]`=2.
3. DIV=5, HIGH=2, load phase 7 → `load_err` pulses one cycle; `busy` stays 0; output unchanged.
4. Second `phase_load` while `busy`=1 (phase 1, then 3) → only phase 1 applied; no `load_err`.
5. Reload phase 0 on a phase-0 channel → zero stretch; `busy` clears at the next period start; the waveform is identical to an unloaded channel.
6. Assert `rst_n` while a channel is in HOLD → all `clk_out`=0 and `busy`=0 immediately; after release, behaviour matches scenario 1.
